// File: rtl/reg_scoreboard.sv
// -----------------------------------------------------------------------------
// reg_scoreboard
//
// Purpose:
//     Tracks in-flight GPR writes between decode and write-back. Each GPR 1..31
//     keeps a small pending-write counter. Decode is stalled when an instruction
//     would read a GPR that still has a write outstanding. It is also stalled
//     when it would push a destination counter beyond MAX_PENDING. A write-back
//     that arrives in the same cycle is taken into account so that the value can
//     flow straight through.
//
// Ports:
//     clk                 in   1   rising-edge clock
//     reset               in   1   asynchronous, active-low reset
//     issue_valid         in   1   decode presents an instruction this cycle
//     issue_write_enable  in   1   presented instruction writes a GPR
//     issue_write_number  in   5   destination GPR of presented instruction
//     read_number1/2      in   5   source GPRs of presented instruction
//     read_use1/2         in   1   corresponding source is consumed
//     wb_valid            in   1   write-back commits a GPR write this cycle
//     wb_number           in   5   GPR being written back
//     stall               out  1   hold presented instruction in decode
//     busy_mask           out  32  bit i set while GPR i has a pending write
//     underflow_err       out  1   sticky: write-back seen with nothing pending
// -----------------------------------------------------------------------------
module reg_scoreboard #(
    parameter int MAX_PENDING = 3,
    parameter int CNT_W       = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        issue_valid,
    input  logic        issue_write_enable,
    input  logic [4:0]  issue_write_number,
    input  logic [4:0]  read_number1,
    input  logic [4:0]  read_number2,
    input  logic        read_use1,
    input  logic        read_use2,
    input  logic        wb_valid,
    input  logic [4:0]  wb_number,
    output logic        stall,
    output logic [31:0] busy_mask,
    output logic        underflow_err
);

    // Pending-write counters for GPR 1..31; GPR 0 has no storage.
    logic [CNT_W-1:0] r_pend [1:31];
    logic             r_underflow;

    // Read view of the counters with GPR 0 hard-wired to "nothing pending",
    // so the lookups below can index with any 5-bit register number.
    logic [CNT_W-1:0] w_pend [0:31];

    logic [CNT_W-1:0] w_src1Pend;
    logic [CNT_W-1:0] w_src2Pend;
    logic [CNT_W-1:0] w_dstPend;
    logic [CNT_W-1:0] w_wbPend;
    logic             w_haz1;
    logic             w_haz2;
    logic             w_full;
    logic             w_incEn;
    logic             w_decEn;
    logic             w_under;
    logic [31:0]      w_incVec;
    logic [31:0]      w_decVec;

    assign w_pend[0]    = '0;
    assign busy_mask[0] = 1'b0;

    genvar gi;
    generate
        for (gi = 1; gi < 32; gi++) begin : g_view
            assign w_pend[gi]    = r_pend[gi];
            assign busy_mask[gi] = (r_pend[gi] != '0);
        end
    endgenerate

    // Hazard and capacity checks. A source with exactly one pending write
    // is readable when that write retires this very cycle. A full destination
    // can accept another issue when one of its writes retires this cycle.
    always_comb begin
        w_src1Pend = w_pend[read_number1];
        w_src2Pend = w_pend[read_number2];
        w_dstPend  = w_pend[issue_write_number];
        w_wbPend   = w_pend[wb_number];

        w_haz1 = read_use1 && (read_number1 != 5'd0) && (w_src1Pend != '0)
                 && !((w_src1Pend == CNT_W'(1)) && wb_valid && (wb_number == read_number1));
        w_haz2 = read_use2 && (read_number2 != 5'd0) && (w_src2Pend != '0)
                 && !((w_src2Pend == CNT_W'(1)) && wb_valid && (wb_number == read_number2));
        w_full = issue_write_enable && (issue_write_number != 5'd0)
                 && (w_dstPend == CNT_W'(MAX_PENDING))
                 && !(wb_valid && (wb_number == issue_write_number));

        stall = issue_valid && (w_haz1 || w_haz2 || w_full);

        w_incEn = issue_valid && !stall && issue_write_enable && (issue_write_number != 5'd0);
        w_decEn = wb_valid && (wb_number != 5'd0) && (w_wbPend != '0);
        w_under = wb_valid && (wb_number != 5'd0) && (w_wbPend == '0);

        w_incVec = w_incEn ? (32'd1 << issue_write_number) : 32'd0;
        w_decVec = w_decEn ? (32'd1 << wb_number) : 32'd0;
    end

    // Counter update. An issue and a retire that hit the same GPR in one
    // cycle cancel out. Distinct GPRs update independently. Increments can
    // never pass MAX_PENDING because a full destination stalls the issue.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 1; i < 32; i++) begin
                r_pend[i] <= '0;
            end
            r_underflow <= 1'b0;
        end else begin
            for (int i = 1; i < 32; i++) begin
                if (w_incVec[i] && !w_decVec[i]) begin
                    r_pend[i] <= r_pend[i] + CNT_W'(1);
                end else if (w_decVec[i] && !w_incVec[i]) begin
                    r_pend[i] <= r_pend[i] - CNT_W'(1);
                end
            end
            if (w_under) begin
                r_underflow <= 1'b1;
            end
        end
    end

    assign underflow_err = r_underflow;

endmodule

// File: tb/tb_reg_scoreboard.sv
// -----------------------------------------------------------------------------
// tb_reg_scoreboard
//
// Purpose:
//     Drives reg_scoreboard through directed scenarios and a randomized run.
//     Every output is compared against a behavioural model that keeps the
//     pending-write count of each GPR as a plain integer.
// -----------------------------------------------------------------------------
module tb_reg_scoreboard;

    localparam int MAX_PENDING = 3;

    logic        clk;
    logic        reset;
    logic        issue_valid;
    logic        issue_write_enable;
    logic [4:0]  issue_write_number;
    logic [4:0]  read_number1;
    logic [4:0]  read_number2;
    logic        read_use1;
    logic        read_use2;
    logic        wb_valid;
    logic [4:0]  wb_number;
    logic        stall;
    logic [31:0] busy_mask;
    logic        underflow_err;

    int passCount;
    int checkCount;

    // Reference model: number of outstanding writes per GPR, plus the sticky flag.
    int pendModel [32];
    bit underModel;

    reg_scoreboard #(.MAX_PENDING(MAX_PENDING), .CNT_W(2)) dut (
        .clk                (clk),
        .reset              (reset),
        .issue_valid        (issue_valid),
        .issue_write_enable (issue_write_enable),
        .issue_write_number (issue_write_number),
        .read_number1       (read_number1),
        .read_number2       (read_number2),
        .read_use1          (read_use1),
        .read_use2          (read_use2),
        .wb_valid           (wb_valid),
        .wb_number          (wb_number),
        .stall              (stall),
        .busy_mask          (busy_mask),
        .underflow_err      (underflow_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got %h, expected %h at %0t", tag, observed, expected, $time);
        end
    endtask

    function automatic logic [31:0] modelBusy();
        logic [31:0] m;
        m = 32'd0;
        for (int r = 1; r < 32; r++) begin
            if (pendModel[r] > 0) m[r] = 1'b1;
        end
        return m;
    endfunction

    // A read blocks if its register has a write in flight, unless that is
    // the single remaining write and it commits this very cycle.
    function automatic bit srcBlocked(input bit use_, input int num);
        if (!use_ || num == 0 || pendModel[num] == 0) return 1'b0;
        if (pendModel[num] == 1 && wb_valid && int'(wb_number) == num) return 1'b0;
        return 1'b1;
    endfunction

    function automatic bit modelStall();
        bit full;
        int d;
        d = int'(issue_write_number);
        full = issue_write_enable && d != 0 && pendModel[d] == MAX_PENDING
               && !(wb_valid && int'(wb_number) == d);
        return issue_valid && (srcBlocked(read_use1, int'(read_number1))
                               || srcBlocked(read_use2, int'(read_number2)) || full);
    endfunction

    // Drive one cycle of inputs (called just after a falling edge). Check
    // the combinational outputs, clock the design, advance the model, and
    // check the registered state.
    task automatic applyStimulus(input bit iv, input bit we, input int wn,
                                 input bit u1, input int r1, input bit u2, input int r2,
                                 input bit wbv, input int wbn, input string tag);
        bit expStall;
        bit accept;
        int newPend [32];
        issue_valid        = iv;
        issue_write_enable = we;
        issue_write_number = 5'(wn);
        read_use1          = u1;
        read_number1       = 5'(r1);
        read_use2          = u2;
        read_number2       = 5'(r2);
        wb_valid           = wbv;
        wb_number          = 5'(wbn);
        #1;
        expStall = modelStall();
        checkOutput({tag, ".stall"}, 32'(stall), 32'(expStall));
        checkOutput({tag, ".busy"}, busy_mask, modelBusy());
        accept = iv && !expStall;
        newPend = pendModel;
        if (accept && we && wn != 0) newPend[wn] = newPend[wn] + 1;
        if (wbv && wbn != 0) begin
            if (pendModel[wbn] > 0) newPend[wbn] = newPend[wbn] - 1;
            else underModel = 1'b1;
        end
        @(posedge clk);
        pendModel = newPend;
        #1;
        checkOutput({tag, ".busyNext"}, busy_mask, modelBusy());
        checkOutput({tag, ".underflow"}, 32'(underflow_err), 32'(underModel));
        @(negedge clk);
    endtask

    task automatic idleInputs();
        issue_valid        = 1'b0;
        issue_write_enable = 1'b0;
        issue_write_number = 5'd0;
        read_use1          = 1'b0;
        read_number1       = 5'd0;
        read_use2          = 1'b0;
        read_number2       = 5'd0;
        wb_valid           = 1'b0;
        wb_number          = 5'd0;
    endtask

    task automatic clearModel();
        for (int r = 0; r < 32; r++) pendModel[r] = 0;
        underModel = 1'b0;
    endtask

    initial begin
        passCount  = 0;
        checkCount = 0;
        clearModel();
        idleInputs();
        reset = 1'b0;
        #2;
        issue_valid  = 1'b1;
        read_use1    = 1'b1;
        read_number1 = 5'd4;
        #1;
        checkOutput("reset.busy", busy_mask, 32'h0);
        checkOutput("reset.stall", 32'(stall), 32'h0);
        checkOutput("reset.underflow", 32'(underflow_err), 32'h0);
        idleInputs();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        // Read-after-write on $5, then same-cycle write-through releases it.
        applyStimulus(1, 1, 5, 0, 0, 0, 0, 0, 0, "raw.issue5");
        checkOutput("raw.mask", busy_mask, 32'h0000_0020);
        applyStimulus(1, 0, 0, 1, 5, 0, 0, 0, 0, "raw.read5");
        applyStimulus(1, 0, 0, 1, 5, 0, 0, 1, 5, "wt.read5wb5");
        checkOutput("wt.mask", busy_mask, 32'h0);

        // Fill $7 to MAX_PENDING, fourth write stalls unless one retires.
        for (int k = 0; k < 3; k++) applyStimulus(1, 1, 7, 0, 0, 0, 0, 0, 0, "full.issue7");
        applyStimulus(1, 1, 7, 0, 0, 0, 0, 0, 0, "full.stall7");
        applyStimulus(1, 1, 7, 0, 0, 0, 0, 1, 7, "full.wb7");
        for (int k = 0; k < 3; k++) applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 7, "full.drain7");
        checkOutput("full.drained", busy_mask, 32'h0);

        // Underflow on $9 is sticky; write-back of $0 changes nothing.
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 9, "under.wb9");
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 0, "under.wb0");
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, "under.idle");

        // $0 is never tracked.
        applyStimulus(1, 1, 0, 1, 0, 1, 0, 0, 0, "zero.a");
        applyStimulus(1, 1, 0, 1, 0, 1, 0, 0, 0, "zero.b");

        // Mid-cycle reset with two writes pending on $3.
        applyStimulus(1, 1, 3, 0, 0, 0, 0, 0, 0, "rst.issue3a");
        applyStimulus(1, 1, 3, 0, 0, 0, 0, 0, 0, "rst.issue3b");
        checkOutput("rst.pre", busy_mask, 32'h0000_0008);
        #2;
        reset = 1'b0;
        #1;
        checkOutput("rst.async", busy_mask, 32'h0);
        checkOutput("rst.underClr", 32'(underflow_err), 32'h0);
        clearModel();
        @(negedge clk);
        reset = 1'b1;
        applyStimulus(1, 0, 0, 1, 3, 0, 0, 0, 0, "rst.read3");

        // Randomized traffic over a small register set to provoke conflicts.
        for (int n = 0; n < 400; n++) begin
            bit iv, we, u1, u2, wbv;
            int wn, r1, r2, wbn;
            iv  = ($urandom_range(0, 3) != 0);
            we  = $urandom_range(0, 1);
            wn  = $urandom_range(0, 6);
            u1  = $urandom_range(0, 1);
            r1  = $urandom_range(0, 6);
            u2  = $urandom_range(0, 1);
            r2  = $urandom_range(0, 6);
            wbv = ($urandom_range(0, 2) != 0);
            wbn = $urandom_range(0, 6);
            // Steer most write-backs to something outstanding; rare strays underflow.
            if (wbv && pendModel[wbn] == 0 && $urandom_range(0, 7) != 0) begin
                for (int r = 1; r < 7; r++) if (pendModel[r] > 0) wbn = r;
            end
            // Leave out a stray write-back aimed at a register being issued
            // in the same cycle.
            if (wbv && wbn != 0 && pendModel[wbn] == 0 && iv && we && wn == wbn) wbv = 1'b0;
            applyStimulus(iv, we, wn, u1, r1, u2, r2, wbv, wbn, "rand");
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
